// File: rtl/pulse_scheduler.sv
// Timed pulse dispatcher: queues (delay, addr) descriptors and releases each one
// `delay` enabled cycles after the previous release, stamped with a free-running
// timebase. Optional macro PULSE_SCHED_LATE_CNT_EN adds a backpressure cycle counter.
module pulse_scheduler #(
    parameter int DELAY_W = 16,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 8,
    parameter int TS_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DELAY_W-1:0]           in_delay,
    input  logic [ADDR_W-1:0]            in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [TS_W-1:0]              out_timestamp,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
`ifdef PULSE_SCHED_LATE_CNT_EN
    ,
    output logic [15:0]                  late_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = DELAY_W + ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic [DELAY_W-1:0] countdown_q, countdown_d;
    logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [TS_W-1:0]    timebase_q, timebase_d;

    logic               push, pop, handshake;
    logic [DELAY_W-1:0] head_delay;
    logic [ADDR_W-1:0]  head_addr;

    assign in_ready   = (count_q < CNT_W'(DEPTH)) && !flush && !reset;
    assign push       = in_valid && in_ready;
    assign out_valid  = (state_q == ST_ISSUE);
    assign handshake  = out_valid && out_ready;
    assign {head_delay, head_addr} = mem_q[rd_ptr_q];

    // A pop is only possible from IDLE or on the ISSUE handshake (back-to-back).
    assign pop = enable && !flush && (count_q != '0) &&
                 ((state_q == ST_IDLE) || ((state_q == ST_ISSUE) && handshake));

    assign timebase_d    = enable ? timebase_q + TS_W'(1) : timebase_q;
    assign count_d       = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    assign out_addr      = hold_addr_q;
    assign out_timestamp = ts_q;
    assign fifo_count    = count_q;
    assign busy          = (state_q != ST_IDLE) || (count_q != '0);

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        hold_addr_d = hold_addr_q;
        ts_d        = ts_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (pop) begin
            hold_addr_d = head_addr;
            countdown_d = head_delay;
            if (head_delay == '0) begin
                state_d = ST_ISSUE;
                ts_d    = timebase_d;
            end else begin
                state_d = ST_WAIT;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (enable) begin
                        countdown_d = countdown_q - DELAY_W'(1);
                        if (countdown_q == DELAY_W'(1)) begin
                            state_d = ST_ISSUE;
                            ts_d    = timebase_d;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (handshake) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_delay, in_addr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            countdown_q <= '0;
            hold_addr_q <= '0;
            ts_q        <= '0;
            timebase_q  <= '0;
        end else begin
            count_q     <= count_d;
            state_q     <= state_d;
            countdown_q <= countdown_d;
            hold_addr_q <= hold_addr_d;
            ts_q        <= ts_d;
            timebase_q  <= timebase_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

`ifdef PULSE_SCHED_LATE_CNT_EN
    logic [15:0] late_q;
    assign late_count = late_q;

    // Saturating count of ISSUE cycles stalled by downstream; survives flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            late_q <= '0;
        end else if (out_valid && !out_ready && (late_q != 16'hFFFF)) begin
            late_q <= late_q + 16'd1;
        end
    end
`endif

endmodule
